exec_step_controller: RTL and testbench
=======================================

Name: exec_step_controller

Overview:
- Sequences execution of the single-cycle RV32I core from the 50 MHz board clock.
- Emits one-cycle `cpu_tick` enable pulses in three ways: manual single-step (button), auto-run at a selectable rate, or free-run.
- Stops on a PC breakpoint or on a halt request.
- Sits between board buttons/switches and the core's clock-enable; replaces ad-hoc divided clocks with a single-domain enable.

Parameters:
- DEBOUNCE_CYCLES, 500_000, stable-input cycles required before a button level is accepted (10 ms at 50 MHz).
- RATE0_DIV, 50_000_000, clk_in cycles between ticks for rate_sel=0 (1 Hz).
- RATE1_DIV, 5_000_000, clk_in cycles between ticks for rate_sel=1 (10 Hz).
- RATE2_DIV, 500_000, clk_in cycles between ticks for rate_sel=2 (100 Hz).
- RATE3_DIV, 1, clk_in cycles between ticks for rate_sel=3 (free-run, tick every cycle).

Ports:
- clk_in  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-high reset
- btn_step  in  1  raw step button, active-high, asynchronous to clk_in
- btn_run  in  1  raw run/stop toggle button, active-high, asynchronous
- rate_sel  in  2  auto-run rate select
- pc  in  32  current core PC
- bp_en  in  1  breakpoint enable
- bp_addr  in  32  breakpoint PC
- halt_req  in  1  level from core (ebreak/ecall decode)
- cpu_tick  out  1  one-cycle clock-enable pulse to core
- state  out  2  0=IDLE, 1=STEP, 2=RUN, 3=HALT
- bp_hit  out  1  sticky; set when stopped by breakpoint
- insn_count  out  32  number of ticks issued since reset

Behaviour:
- Reset: `cpu_tick`=0, `state`=IDLE, `bp_hit`=0, `insn_count`=0. Prescaler, debouncers and synchronisers are cleared.
- Button path: 2-FF synchroniser, then a debounce counter. The accepted level changes only after DEBOUNCE_CYCLES consecutive identical samples. A rising edge of the accepted level gives a one-cycle event (`step_ev`, `run_ev`).
- Prescaler:
  - Counts 0..DIV-1, where DIV is selected by `rate_sel`.
  - `rate_tick` is asserted when count==DIV-1, then count wraps to 0.
  - Runs only in RUN; held at 0 otherwise.
  - A `rate_sel` change mid-run takes effect immediately. If count ≥ new DIV-1, `rate_tick` fires on the next cycle and count wraps.
- Stop condition, evaluated combinationally each cycle: `stop = halt_req | (bp_en & pc==bp_addr)`.
- FSM transitions:
  - IDLE: `step_ev` → STEP. `run_ev` → RUN.
  - STEP: assert `cpu_tick` for exactly 1 cycle, `insn_count`++, then → IDLE. A single step ignores `stop`, so stepping off a breakpoint is possible.
  - RUN:
    - On `rate_tick` with `stop`=0: `cpu_tick`=1 and `insn_count`++.
    - `stop`=1 (checked before the tick, same cycle): no tick; → HALT; `bp_hit` ← (bp_en & pc==bp_addr).
    - Exception: the first tick after entering RUN ignores the breakpoint (not `halt_req`), so Run resumes from a breakpoint PC.
    - `run_ev` → IDLE, with no tick that cycle.
  - HALT:
    - `run_ev` → RUN, clearing `bp_hit`.
    - `step_ev` → STEP, keeping `bp_hit` until the next RUN entry.
- Simultaneous `step_ev` and `run_ev`: `run_ev` wins.
- `step_ev` in RUN: ignored.
- Tick latency:
  - STEP: `cpu_tick` asserts 1 cycle after `step_ev`.
  - RUN: the first `cpu_tick` comes DIV cycles after entering RUN.
- `cpu_tick` is never high for 2 consecutive cycles, except in RUN with DIV=1.
- `insn_count`: 32-bit, wraps 0xFFFFFFFF→0 silently.
- Reset mid-operation: every output returns to its reset value on the same edge. No tick is issued until a new button event.

Decomposition:
- Package `exec_ctrl_pkg`:
  - `typedef enum logic [1:0] exec_state_t {IDLE, STEP, RUN, HALT}`.
  - Rate-divider defaults as localparams.
- Sub-module `btn_debounce`, instantiated ×2:
  - Synchroniser, debounce counter and rising-edge pulse.
  - Parameter DEBOUNCE_CYCLES.
  - Ports: clk_in, rst, btn_raw, btn_level, btn_rise.

Test Plan:
- DEBOUNCE_CYCLES=4: press `btn_step` cleanly for 10 cycles → exactly one `cpu_tick` pulse; state returns to IDLE; `insn_count`=1. A 2-cycle glitch → no tick.
- RATE1_DIV=5, rate_sel=1, `run_ev` → `cpu_tick` every 5 cycles, first one 5 cycles after RUN entry. Second `run_ev` → IDLE, no further ticks. `insn_count` equals the pulse count.
- bp_en=1, bp_addr=0x10, core model advancing pc by 4 per tick from 0 in RUN → 4 ticks (pc 0,4,8,C), then HALT with `bp_hit`=1 and pc=0x10. `run_ev` → next tick issued at pc=0x10; `bp_hit`=0.
- `halt_req`=1 during RUN with rate_sel=3 → no tick in the cycle `halt_req` is seen; state=HALT; `bp_hit`=0. `step_ev` in HALT → exactly one tick.
- Assert `rst` mid-RUN between ticks → `cpu_tick`=0, state=IDLE, `insn_count`=0 immediately. No ticks for 100 cycles afterwards.
- `insn_count` forced near wrap (0xFFFFFFFE via prior ticks, or a small-width override bench) → wraps to 0 after 2 ticks with no other side effects.

Source files
------------

// File: rtl/exec_step_controller_pkg.sv
// Shared types and default timing constants for the execution step controller.
package exec_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } exec_state_t;

  // Defaults assume the 50 MHz board clock.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500_000;
  localparam int unsigned DEF_RATE0_DIV       = 50_000_000;
  localparam int unsigned DEF_RATE1_DIV       = 5_000_000;
  localparam int unsigned DEF_RATE2_DIV       = 500_000;
  localparam int unsigned DEF_RATE3_DIV       = 1;

endpackage

// File: rtl/exec_step_controller_debounce.sv
// Button conditioner: 2-FF synchroniser, debounce counter, rising-edge pulse.
module btn_debounce
  import exec_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_in,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  // r_cnt counts consecutive samples that disagree with the accepted level.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= btn_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign btn_level = r_level;
  assign btn_rise  = r_level & ~r_level_d;

endmodule

// File: rtl/exec_step_controller.sv
// Drives the core clock-enable: manual step, rate-divided auto-run or free-run,
// stopping on a PC breakpoint or a halt request from the core.
module exec_step_controller
  import exec_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned RATE0_DIV       = DEF_RATE0_DIV,
  parameter int unsigned RATE1_DIV       = DEF_RATE1_DIV,
  parameter int unsigned RATE2_DIV       = DEF_RATE2_DIV,
  parameter int unsigned RATE3_DIV       = DEF_RATE3_DIV,
  parameter int unsigned INSN_CNT_W      = 32
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        btn_step,
  input  logic        btn_run,
  input  logic [1:0]  rate_sel,
  input  logic [31:0] pc,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic        halt_req,
  output logic        cpu_tick,
  output logic [1:0]  state,
  output logic        bp_hit,
  output logic [31:0] insn_count
);

  exec_state_t           r_state;
  exec_state_t           w_next;
  logic [31:0]           r_presc;
  logic [31:0]           w_div;
  logic                  w_rate_tick;
  logic                  r_first;
  logic                  r_bp_hit;
  logic [INSN_CNT_W-1:0] r_insn_count;
  logic                  w_tick;
  logic                  w_step_ev;
  logic                  w_run_ev;
  logic                  w_step_level;
  logic                  w_run_level;
  logic                  w_unused_levels;
  logic                  w_bp_match;
  logic                  w_stop;
  logic                  w_enter_run;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk_in    (clk_in),
    .rst       (rst),
    .btn_raw   (btn_step),
    .btn_level (w_step_level),
    .btn_rise  (w_step_ev)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
    .clk_in    (clk_in),
    .rst       (rst),
    .btn_raw   (btn_run),
    .btn_level (w_run_level),
    .btn_rise  (w_run_ev)
  );

  // Only the press events matter to the sequencer; levels are left for probing.
  assign w_unused_levels = w_step_level ^ w_run_level;

  always_comb begin
    w_div = 32'(RATE3_DIV);
    case (rate_sel)
      2'd0:    w_div = 32'(RATE0_DIV);
      2'd1:    w_div = 32'(RATE1_DIV);
      2'd2:    w_div = 32'(RATE2_DIV);
      default: w_div = 32'(RATE3_DIV);
    endcase
  end

  // ">=" lets a mid-run switch to a shorter divider fire at once and wrap.
  assign w_rate_tick = (r_state == RUN) && (r_presc >= (w_div - 32'd1));
  assign w_bp_match  = bp_en && (pc == bp_addr);
  // The breakpoint is masked until the first tick of a run so Run can leave it.
  assign w_stop      = halt_req | (w_bp_match & ~r_first);
  assign w_enter_run = (r_state != RUN) && (w_next == RUN);

  always_comb begin
    w_next = r_state;
    w_tick = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_run_ev)       w_next = RUN;
        else if (w_step_ev) w_next = STEP;
      end
      STEP: begin
        w_tick = 1'b1;
        w_next = IDLE;
      end
      RUN: begin
        if (w_run_ev)         w_next = IDLE;
        else if (w_stop)      w_next = HALT;
        else if (w_rate_tick) w_tick = 1'b1;
      end
      HALT: begin
        if (w_run_ev)       w_next = RUN;
        else if (w_step_ev) w_next = STEP;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_presc      <= '0;
      r_first      <= 1'b0;
      r_bp_hit     <= 1'b0;
      r_insn_count <= '0;
    end else begin
      r_state <= w_next;

      if ((r_state == RUN) && (w_next == RUN)) begin
        r_presc <= w_rate_tick ? 32'd0 : r_presc + 32'd1;
      end else begin
        r_presc <= '0;
      end

      if (w_enter_run)                    r_first <= 1'b1;
      else if (w_tick && r_state == RUN) r_first <= 1'b0;

      if (w_enter_run)                                  r_bp_hit <= 1'b0;
      else if ((r_state == RUN) && (w_next == HALT))   r_bp_hit <= w_bp_match;

      if (w_tick) r_insn_count <= r_insn_count + INSN_CNT_W'(1);
    end
  end

  always_comb begin
    insn_count                   = '0;
    insn_count[INSN_CNT_W-1:0]   = r_insn_count;
  end

  assign cpu_tick = w_tick;
  assign state    = r_state;
  assign bp_hit   = r_bp_hit;

endmodule

// File: tb/tb_exec_step_controller.sv
// Directed bench for exec_step_controller: short debounce, small dividers and an
// 8-bit instruction counter so every path, including counter wrap, is reachable.
module tb_exec_step_controller;
  import exec_ctrl_pkg::*;

  localparam int unsigned CNT_W = 8;
  localparam bit B_STEP = 1'b0;
  localparam bit B_RUN  = 1'b1;

  logic        clk_in   = 1'b0;
  logic        rst      = 1'b1;
  logic        btn_step = 1'b0;
  logic        btn_run  = 1'b0;
  logic [1:0]  rate_sel = 2'd0;
  logic [31:0] pc;
  logic        bp_en    = 1'b0;
  logic [31:0] bp_addr  = 32'd0;
  logic        halt_req = 1'b0;
  logic        cpu_tick;
  logic [1:0]  state;
  logic        bp_hit;
  logic [31:0] insn_count;

  logic        pc_load     = 1'b1;
  logic [31:0] pc_load_val = 32'd0;
  int          tick_cnt    = 0;
  int          tick_base   = 0;
  int          n_pass      = 0;
  int          n_total     = 0;

  typedef struct {
    logic [1:0] sel;
    int         exp_first;
    int         exp_period;
  } rate_vec_t;

  rate_vec_t vecs [4];

  exec_step_controller #(
    .DEBOUNCE_CYCLES (4),
    .RATE0_DIV       (8),
    .RATE1_DIV       (5),
    .RATE2_DIV       (3),
    .RATE3_DIV       (1),
    .INSN_CNT_W      (CNT_W)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .btn_step   (btn_step),
    .btn_run    (btn_run),
    .rate_sel   (rate_sel),
    .pc         (pc),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .halt_req   (halt_req),
    .cpu_tick   (cpu_tick),
    .state      (state),
    .bp_hit     (bp_hit),
    .insn_count (insn_count)
  );

  // Clock / reset block and core model
  always #10 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (pc_load)       pc <= pc_load_val;
    else if (cpu_tick) pc <= pc + 32'd4;
  end

  always @(posedge clk_in) begin
    if (cpu_tick) tick_cnt <= tick_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_count();
    logic [31:0] d;
    d = 32'(tick_cnt - tick_base);
    return d & ((32'd1 << CNT_W) - 32'd1);
  endfunction

  // Driver tasks
  task automatic cyc();
    @(posedge clk_in);
    #2;
  endtask

  task automatic btn_drive(input bit which, input logic v);
    if (which) btn_run = v;
    else       btn_step = v;
  endtask

  task automatic press_until(input bit which, input exec_state_t target, input string name);
    repeat (8) cyc();
    btn_drive(which, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (state == target) break;
    end
    btn_drive(which, 1'b0);
    chk(name, 32'(state), 32'(target));
  endtask

  task automatic btn_pulse(input bit which, input int len, input int tail,
                           output int first_j, output int n);
    first_j = -1;
    n = 0;
    btn_drive(which, 1'b1);
    for (int j = 1; j <= len + tail; j++) begin
      cyc();
      if (cpu_tick) begin
        if (first_j < 0) first_j = j;
        n++;
      end
      if (j == len) btn_drive(which, 1'b0);
    end
  endtask

  initial begin
    int fj, n, first, second, nt, t0, found;

    // first tick index from the first RUN cycle is DIV-1
    vecs[0] = '{sel: 2'd0, exp_first: 7, exp_period: 8};
    vecs[1] = '{sel: 2'd1, exp_first: 4, exp_period: 5};
    vecs[2] = '{sel: 2'd2, exp_first: 2, exp_period: 3};
    vecs[3] = '{sel: 2'd3, exp_first: 0, exp_period: 1};

    repeat (3) cyc();
    chk("reset_cpu_tick", 32'(cpu_tick), 32'd0);
    chk("reset_state", 32'(state), 32'(IDLE));
    chk("reset_bp_hit", 32'(bp_hit), 32'd0);
    chk("reset_insn_count", insn_count, 32'd0);
    rst = 1'b0;
    cyc();
    pc_load = 1'b0;
    tick_base = tick_cnt;

    // Clean step press: 2 sync + 4 debounce + 1 edge cycle before the tick
    btn_pulse(B_STEP, 10, 12, fj, n);
    chk("step_tick_count", 32'(n), 32'd1);
    chk("step_latency", 32'(fj), 32'd7);
    chk("step_state", 32'(state), 32'(IDLE));
    chk("step_insn_count", insn_count, 32'd1);

    // Two-cycle glitch must be rejected
    btn_pulse(B_STEP, 2, 12, fj, n);
    chk("glitch_tick_count", 32'(n), 32'd0);
    chk("glitch_insn_count", insn_count, 32'd1);

    // Rate table
    for (int k = 0; k < 4; k++) begin
      rate_sel = vecs[k].sel;
      press_until(B_RUN, RUN, "rate_run_entry");
      first = -1; second = -1; nt = 0;
      for (int j = 0; j < 40; j++) begin
        if (j > 0) cyc();
        if (cpu_tick) begin
          if (nt == 0)      first = j;
          else if (nt == 1) second = j;
          nt++;
        end
        if (nt == 3) break;
      end
      chk("rate_first_tick", 32'(first), 32'(vecs[k].exp_first));
      chk("rate_period", 32'(second - first), 32'(vecs[k].exp_period));
      cyc();
      chk("rate_insn_count", insn_count, exp_count());
      press_until(B_RUN, IDLE, "rate_run_exit");
      t0 = tick_cnt;
      repeat (20) cyc();
      chk("rate_idle_no_ticks", 32'(tick_cnt - t0), 32'd0);
      chk("rate_idle_insn_count", insn_count, exp_count());
    end

    // Breakpoint at 0x10 with pc advancing by 4 per tick from 0
    rate_sel = 2'd2;
    bp_addr = 32'h10;
    bp_en = 1'b1;
    pc_load_val = 32'd0;
    pc_load = 1'b1;
    cyc();
    pc_load = 1'b0;
    t0 = tick_cnt;
    press_until(B_RUN, RUN, "bp_run_entry");
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (state == HALT) break;
    end
    chk("bp_halt_state", 32'(state), 32'(HALT));
    chk("bp_tick_count", 32'(tick_cnt - t0), 32'd4);
    chk("bp_hit_set", 32'(bp_hit), 32'd1);
    chk("bp_halt_pc", pc, 32'h10);
    press_until(B_RUN, RUN, "bp_resume_entry");
    chk("bp_hit_cleared", 32'(bp_hit), 32'd0);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (cpu_tick) begin
        found = 1;
        break;
      end
      cyc();
    end
    chk("bp_resume_tick_seen", 32'(found), 32'd1);
    chk("bp_resume_tick_pc", pc, 32'h10);
    bp_en = 1'b0;
    press_until(B_RUN, IDLE, "bp_run_exit");

    // halt_req in free-run, then single step out of HALT
    rate_sel = 2'd3;
    press_until(B_RUN, RUN, "halt_run_entry");
    repeat (3) cyc();
    halt_req = 1'b1;
    #1;
    chk("halt_tick_suppressed", 32'(cpu_tick), 32'd0);
    t0 = tick_cnt;
    cyc();
    chk("halt_state", 32'(state), 32'(HALT));
    chk("halt_bp_hit", 32'(bp_hit), 32'd0);
    chk("halt_no_tick", 32'(tick_cnt - t0), 32'd0);
    btn_pulse(B_STEP, 6, 12, fj, n);
    chk("halt_step_ticks", 32'(n), 32'd1);
    chk("halt_step_state", 32'(state), 32'(IDLE));
    halt_req = 1'b0;

    // Counter wrap in free-run
    press_until(B_RUN, RUN, "wrap_run_entry");
    found = 0;
    for (int i = 0; i < 400; i++) begin
      if (insn_count == 32'hFE) begin
        found = 1;
        break;
      end
      cyc();
    end
    chk("wrap_reach_fe", 32'(found), 32'd1);
    cyc();
    chk("wrap_ff", insn_count, 32'hFF);
    cyc();
    chk("wrap_zero", insn_count, 32'h0);
    chk("wrap_state", 32'(state), 32'(RUN));
    chk("wrap_bp_hit", 32'(bp_hit), 32'd0);
    press_until(B_RUN, IDLE, "wrap_run_exit");
    chk("wrap_insn_count", insn_count, exp_count());

    // Asynchronous reset between ticks mid-run
    rate_sel = 2'd0;
    press_until(B_RUN, RUN, "rst_run_entry");
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (cpu_tick) begin
        found = 1;
        break;
      end
      cyc();
    end
    chk("rst_first_tick_seen", 32'(found), 32'd1);
    cyc();
    cyc();
    chk("rst_pre_state", 32'(state), 32'(RUN));
    #3;
    rst = 1'b1;
    #1;
    chk("rst_cpu_tick", 32'(cpu_tick), 32'd0);
    chk("rst_state", 32'(state), 32'(IDLE));
    chk("rst_insn_count", insn_count, 32'd0);
    chk("rst_bp_hit", 32'(bp_hit), 32'd0);
    cyc();
    cyc();
    rst = 1'b0;
    tick_base = tick_cnt;
    t0 = tick_cnt;
    repeat (100) cyc();
    chk("rst_no_ticks_after", 32'(tick_cnt - t0), 32'd0);
    chk("rst_idle_after", 32'(state), 32'(IDLE));
    chk("rst_insn_after", insn_count, exp_count());

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
